// File: rtl/poly_arith_pkg.sv
// Shared types and constants for the ML-KEM polynomial arithmetic controllers.
package poly_arith_pkg;

    localparam int unsigned COEFF_W = 12;
    localparam int unsigned Q       = 3329;
    localparam int unsigned N_COEFF = 256;

    typedef logic [COEFF_W-1:0] coeff_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } ctrl_state_e;

endpackage

// File: rtl/poly_addsub_ctrl_if.sv
// Handshake and memory-port bundle between the add/sub sequencer and its environment.
interface poly_addsub_ctrl_if
    import poly_arith_pkg::*;
#(
    parameter int unsigned ADDR_W = 8
);

    logic              start_i;
    logic              op_sub_i;
    logic              hold_i;
    logic              busy_o;
    logic              done_o;
    logic              rd_en_o;
    logic [ADDR_W-1:0] rd_addr_o;
    coeff_t            a_data_i;
    coeff_t            b_data_i;
    logic              wr_en_o;
    logic [ADDR_W-1:0] wr_addr_o;
    coeff_t            wr_data_o;

    modport master (
        input  start_i, op_sub_i, hold_i, a_data_i, b_data_i,
        output busy_o, done_o, rd_en_o, rd_addr_o, wr_en_o, wr_addr_o, wr_data_o
    );

    modport slave (
        output start_i, op_sub_i, hold_i, a_data_i, b_data_i,
        input  busy_o, done_o, rd_en_o, rd_addr_o, wr_en_o, wr_addr_o, wr_data_o
    );

endinterface

// File: rtl/mod_add.sv
// Combinational modular adder: sum = (a + b) mod Q for a, b < Q.
module mod_add
    import poly_arith_pkg::*;
(
    input  coeff_t a_i,
    input  coeff_t b_i,
    output coeff_t sum_c
);

    localparam int unsigned SUM_W = COEFF_W + 1;

    logic [SUM_W-1:0] raw;
    logic [SUM_W-1:0] red;

    always_comb begin
        raw   = SUM_W'(a_i) + SUM_W'(b_i);
        red   = (raw >= SUM_W'(Q)) ? (raw - SUM_W'(Q)) : raw;
        sum_c = COEFF_W'(red);
    end

endmodule

// File: rtl/poly_addsub_ctrl.sv
// Streams one polynomial pair through mod_add: c[k] = a[k] +/- b[k] mod Q.
// Two-stage pipeline (memory read latency, registered result) with arbiter hold.
module poly_addsub_ctrl
    import poly_arith_pkg::*;
#(
    parameter int unsigned N      = N_COEFF,
    parameter int unsigned ADDR_W = $clog2(N)
) (
    input  logic               clk,
    input  logic               rst,
    poly_addsub_ctrl_if.master bus
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N - 1);

    ctrl_state_e       state_q, state_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              op_sub_q, op_sub_d;
    logic              rd_en_q, rd_en_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic              v1_q, v1_d;
    logic [ADDR_W-1:0] addr1_q, addr1_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    coeff_t            wr_data_q, wr_data_d;

    logic              held;
    coeff_t            b_eff;
    coeff_t            sum;

    // Hold only matters while the pipeline is active.
    assign held = bus.hold_i && ((state_q == ST_RUN) || (state_q == ST_DRAIN));

    // Subtract as a + (Q - b); zero stays zero so the adder input is always < Q.
    always_comb begin
        b_eff = bus.b_data_i;
        if (op_sub_q) begin
            b_eff = (bus.b_data_i == '0) ? '0 : (coeff_t'(Q) - bus.b_data_i);
        end
    end

    mod_add u_mod_add (
        .a_i   (bus.a_data_i),
        .b_i   (b_eff),
        .sum_c (sum)
    );

    always_comb begin
        state_d   = state_q;
        op_sub_d  = op_sub_q;
        rd_en_d   = rd_en_q;
        rd_addr_d = rd_addr_q;
        v1_d      = v1_q;
        addr1_d   = addr1_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.start_i) begin
                    state_d   = ST_RUN;
                    op_sub_d  = bus.op_sub_i;
                    rd_en_d   = 1'b1;
                    rd_addr_d = '0;
                end
            end
            ST_RUN: begin
                if (!held) begin
                    rd_addr_d = rd_addr_q + ADDR_W'(1);
                    if (rd_addr_q == LAST_ADDR) begin
                        rd_en_d = 1'b0;
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (!held && !v1_q) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A held cycle consumes nothing; the memories keep presenting the same data.
        if (!held) begin
            v1_d    = rd_en_q;
            addr1_d = rd_addr_q;
            wr_en_d = v1_q;
            if (v1_q) begin
                wr_addr_d = addr1_q;
                wr_data_d = sum;
            end
        end

        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            op_sub_q  <= 1'b0;
            rd_en_q   <= 1'b0;
            rd_addr_q <= '0;
            v1_q      <= 1'b0;
            addr1_q   <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            op_sub_q  <= op_sub_d;
            rd_en_q   <= rd_en_d;
            rd_addr_q <= rd_addr_d;
            v1_q      <= v1_d;
            addr1_q   <= addr1_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign bus.busy_o    = busy_q;
    assign bus.done_o    = done_q;
    // Read strobe is gated by hold in the same cycle so a held cycle never advances the memories.
    assign bus.rd_en_o   = rd_en_q && !bus.hold_i;
    assign bus.rd_addr_o = rd_addr_q;
    assign bus.wr_en_o   = wr_en_q;
    assign bus.wr_addr_o = wr_addr_q;
    assign bus.wr_data_o = wr_data_q;

endmodule

// File: tb/tb_poly_addsub_ctrl.sv
// Self-checking bench for poly_addsub_ctrl against an arithmetic reference model.
module tb_poly_addsub_ctrl;
    import poly_arith_pkg::*;

    localparam int unsigned N      = 256;
    localparam int unsigned ADDR_W = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    poly_addsub_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

    poly_addsub_ctrl #(.N(N), .ADDR_W(ADDR_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    coeff_t      a_mem [N];
    coeff_t      b_mem [N];
    int unsigned res   [N];
    coeff_t      a_rd_q = '0;
    coeff_t      b_rd_q = '0;

    // Memory model: one-cycle read latency, output held while not read.
    always @(posedge clk) begin
        if (bus.rd_en_o) begin
            a_rd_q <= a_mem[bus.rd_addr_o];
            b_rd_q <= b_mem[bus.rd_addr_o];
        end
    end

    assign bus.a_data_i = a_rd_q;
    assign bus.b_data_i = b_rd_q;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input longint unsigned got, input longint unsigned exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int unsigned ref_coeff(input int unsigned a, input int unsigned b, input bit sub);
        if (sub) return (a + Q - b) % Q;
        return (a + b) % Q;
    endfunction

    task automatic check_outputs_zero(input string pfx);
        check_eq({pfx, "_busy"},    bus.busy_o,    0);
        check_eq({pfx, "_done"},    bus.done_o,    0);
        check_eq({pfx, "_rd_en"},   bus.rd_en_o,   0);
        check_eq({pfx, "_rd_addr"}, bus.rd_addr_o, 0);
        check_eq({pfx, "_wr_en"},   bus.wr_en_o,   0);
        check_eq({pfx, "_wr_addr"}, bus.wr_addr_o, 0);
        check_eq({pfx, "_wr_data"}, bus.wr_data_o, 0);
    endtask

    // One run starting from IDLE; called just after a rising edge.
    task automatic do_run(input bit op, input int unsigned hold_pct, input bit toggle_op,
                          input bit busy_pulses, input int abort_at);
        int exp_done  = int'(N) + 3;
        int wr_idx    = 0;
        bit prev_held = 1'b0;
        bit hold;
        int c;
        bus.start_i  = 1'b1;
        bus.op_sub_i = op;
        bus.hold_i   = ($urandom_range(0, 99) < hold_pct);
        @(negedge clk);
        check_eq("idle_busy", bus.busy_o, 0);
        @(posedge clk); #1;
        for (c = 1; c <= exp_done && c < 4 * int'(N); c++) begin
            hold = (hold_pct > 0) && ($urandom_range(0, 99) < hold_pct);
            bus.hold_i  = hold;
            bus.start_i = busy_pulses && (c == 10 || c == int'(N) + 3);
            if (toggle_op) bus.op_sub_i = ~bus.op_sub_i;
            if (hold && c < exp_done) exp_done++;
            @(negedge clk);
            check_eq("busy", bus.busy_o, 1);
            check_eq("done", bus.done_o, (c == exp_done));
            if (hold && c < exp_done) check_eq("rd_en_held", bus.rd_en_o, 0);
            if (prev_held) check_eq("wr_en_after_hold", bus.wr_en_o, 0);
            if (hold_pct == 0) check_eq("wr_en_window", bus.wr_en_o, (c >= 3 && c <= int'(N) + 2));
            if (bus.wr_en_o) begin
                if (wr_idx < int'(N)) begin
                    check_eq("wr_addr", bus.wr_addr_o, wr_idx);
                    check_eq("wr_data", bus.wr_data_o, ref_coeff(a_mem[wr_idx], b_mem[wr_idx], op));
                    res[wr_idx] = bus.wr_data_o;
                end
                wr_idx++;
                if (wr_idx - 1 == abort_at) begin
                    rst = 1'b1;
                    #1;
                    check_outputs_zero("rst_mid");
                    bus.hold_i  = 1'b0;
                    bus.start_i = 1'b0;
                    repeat (3) begin
                        @(negedge clk);
                        check_eq("rst_wr_en", bus.wr_en_o, 0);
                        check_eq("rst_busy",  bus.busy_o,  0);
                    end
                    @(posedge clk); #1;
                    rst = 1'b0;
                    return;
                end
            end
            prev_held = hold && (c < exp_done);
            @(posedge clk); #1;
        end
        bus.hold_i  = 1'b0;
        bus.start_i = 1'b0;
        check_eq("run_end",  c, exp_done + 1);
        check_eq("wr_count", wr_idx, N);
    endtask

    task automatic fill_random();
        for (int k = 0; k < int'(N); k++) begin
            a_mem[k] = coeff_t'($urandom_range(0, Q - 1));
            b_mem[k] = coeff_t'($urandom_range(0, Q - 1));
        end
    endtask

    initial begin
        bus.start_i  = 1'b0;
        bus.op_sub_i = 1'b0;
        bus.hold_i   = 1'b0;
        #2 rst = 1'b1;
        #1;
        check_outputs_zero("reset");
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Add, no hold
        for (int k = 0; k < int'(N); k++) begin
            a_mem[k] = coeff_t'(k);
            b_mem[k] = coeff_t'(3328);
        end
        do_run(1'b0, 0, 1'b0, 1'b0, -1);
        check_eq("add_c0",   res[0],   3328);
        check_eq("add_c1",   res[1],   0);
        check_eq("add_c255", res[255], 254);

        // Subtract, op toggled after start
        for (int k = 0; k < int'(N); k++) begin
            a_mem[k] = coeff_t'(5);
            b_mem[k] = coeff_t'(k);
        end
        do_run(1'b1, 0, 1'b1, 1'b0, -1);
        check_eq("sub_c0",   res[0],   5);
        check_eq("sub_c5",   res[5],   0);
        check_eq("sub_c6",   res[6],   3328);
        check_eq("sub_c255", res[255], 3079);

        // Random data with random hold
        fill_random();
        do_run(1'b0, 30, 1'b0, 1'b0, -1);
        fill_random();
        do_run(1'b1, 30, 1'b0, 1'b0, -1);

        // Start pulses at cycles 10 and N+3 ignored; next start at N+4 accepted
        fill_random();
        do_run(1'b0, 0, 1'b0, 1'b1, -1);
        do_run(1'b1, 0, 1'b0, 1'b0, -1);

        // Reset at write 100, then a clean run
        fill_random();
        do_run(1'b0, 0, 1'b0, 1'b0, 100);
        do_run(1'b0, 20, 1'b0, 1'b0, -1);

        // Boundary operands
        fill_random();
        a_mem[0] = coeff_t'(3328); b_mem[0] = coeff_t'(3328);
        a_mem[1] = coeff_t'(0);    b_mem[1] = coeff_t'(0);
        a_mem[2] = coeff_t'(0);    b_mem[2] = coeff_t'(3328);
        a_mem[3] = coeff_t'(3328); b_mem[3] = coeff_t'(0);
        do_run(1'b0, 10, 1'b0, 1'b0, -1);
        check_eq("bnd_add_max",  res[0], 3327);
        check_eq("bnd_add_zero", res[1], 0);
        do_run(1'b1, 10, 1'b0, 1'b0, -1);
        check_eq("bnd_sub_zero", res[1], 0);
        check_eq("bnd_sub_0_max", res[2], 1);
        check_eq("bnd_sub_max_0", res[3], 3328);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
